// File: rtl/neuron_pkg.sv
// neuron_pkg: register map, STATUS/CTRL bit positions, MAC FSM encoding and
// small helpers shared by neuron_mac_core and neuron_axil_mac.
package neuron_pkg;

    localparam logic [31:0] CTRL_OFFSET   = 32'h00;
    localparam logic [31:0] STATUS_OFFSET = 32'h04;
    localparam logic [31:0] BIAS_OFFSET   = 32'h08;
    localparam logic [31:0] RESULT_OFFSET = 32'h0C;
    localparam logic [31:0] INPUT_BASE    = 32'h10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_OVF_BIT  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    // Wide enough that N full-scale products can never wrap.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n) + 1;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/neuron_mac_core.sv
// neuron_mac_core: sequential multiply-accumulate, bias/scale, saturation and
// activation. Defining NEURON_RELU_EN selects ReLU, otherwise linear output.
module neuron_mac_core
    import neuron_pkg::*;
#(
    parameter int W         = 32,
    parameter int N         = 8,
    parameter int FRAC_BITS = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr_done,
    input  logic             clr_ovf,
    input  logic [W-1:0]     bias,
    output logic [IDX_W-1:0] op_idx,
    input  logic [W-1:0]     op_input,
    input  logic [W-1:0]     op_weight,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [W-1:0]     result
);

    localparam int ACC_W = acc_width(W, N);

    mac_state_t               state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*W-1:0]    product;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic [W-1:0]             sat_val;
    logic                     sat_flag;
    logic [W-1:0]             sat_q;
    logic                     sat_ovf_q;
    logic [W-1:0]             act_val;

    assign busy     = (state != ST_IDLE);
    assign product  = $signed(op_input) * $signed(op_weight);
    assign bias_ext = {{(ACC_W-W){bias[W-1]}}, bias};

    // Saturation: the scaled sum fits in W bits only if every bit above W-1 matches the sign.
    always_comb begin
        shifted  = (acc + (bias_ext <<< FRAC_BITS)) >>> FRAC_BITS;
        sat_flag = (shifted[ACC_W-1:W-1] != {(ACC_W-W+1){shifted[ACC_W-1]}});
        sat_val  = shifted[W-1:0];
        if (sat_flag) begin
            sat_val = shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_comb begin
`ifdef NEURON_RELU_EN
        act_val = sat_q[W-1] ? '0 : sat_q;
`else
        act_val = sat_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            op_idx    <= '0;
            sat_q     <= '0;
            sat_ovf_q <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (clr_done) done <= 1'b0;
            if (clr_ovf)  ovf  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        op_idx <= '0;
                        done   <= 1'b0;
                        ovf    <= 1'b0;
                        state  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + {{(ACC_W-2*W){product[2*W-1]}}, product};
                    if (op_idx == IDX_W'(N - 1)) begin
                        state <= ST_SCALE;
                    end else begin
                        op_idx <= op_idx + 1'b1;
                    end
                end
                ST_SCALE: begin
                    sat_q     <= sat_val;
                    sat_ovf_q <= sat_flag;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    result <= act_val;
                    done   <= 1'b1;
                    if (sat_ovf_q) ovf <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/neuron_axil_mac.sv
// neuron_axil_mac: AXI4-Lite slave and register bank around neuron_mac_core.
// Activation is selected in the core by NEURON_RELU_EN.
module neuron_axil_mac
    import neuron_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_INPUTS           = 8,
    parameter int FRAC_BITS          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            irq
);

    localparam int W      = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [31:0] WEIGHT_BASE = INPUT_BASE + 32'(4 * N_INPUTS);
    localparam logic [31:0] MAP_END     = INPUT_BASE + 32'(8 * N_INPUTS);

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("neuron_axil_mac: only a 32-bit data width is supported");
    end
    if (N_INPUTS < 1 || N_INPUTS > 64) begin : g_bad_n_inputs
        $error("neuron_axil_mac: N_INPUTS must be in 1..64");
    end
    if (16 + 8 * N_INPUTS > 2 ** C_S_AXI_ADDR_WIDTH) begin : g_bad_addr_width
        $error("neuron_axil_mac: address width too small for the register map");
    end

    logic             irq_en;
    logic [W-1:0]     bias_reg;
    logic [W-1:0]     input_reg  [N_INPUTS];
    logic [W-1:0]     weight_reg [N_INPUTS];

    logic [31:0]      wr_addr, rd_addr;
    logic             wr_en, rd_en;
    logic             wr_in_sel, wr_wt_sel, rd_in_sel, rd_wt_sel;
    logic [IDX_W-1:0] wr_in_idx, wr_wt_idx, rd_in_idx, rd_wt_idx;
    logic             wr_start, wr_data_reg, wr_err;
    logic             core_start, clr_done, clr_ovf;
    logic [W-1:0]     rd_val;

    logic [IDX_W-1:0] core_idx;
    logic             busy, done, ovf;
    logic [W-1:0]     result;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign wr_addr = 32'({s_axi_awaddr[ADDR_W-1:2], 2'b00});
    assign rd_addr = 32'({s_axi_araddr[ADDR_W-1:2], 2'b00});
    assign wr_en   = s_axi_awready && s_axi_awvalid && s_axi_wready && s_axi_wvalid;
    assign rd_en   = s_axi_arready && s_axi_arvalid;

    always_comb begin
        wr_in_sel = (wr_addr >= INPUT_BASE) && (wr_addr < WEIGHT_BASE);
        wr_wt_sel = (wr_addr >= WEIGHT_BASE) && (wr_addr < MAP_END);
        rd_in_sel = (rd_addr >= INPUT_BASE) && (rd_addr < WEIGHT_BASE);
        rd_wt_sel = (rd_addr >= WEIGHT_BASE) && (rd_addr < MAP_END);
        wr_in_idx = IDX_W'((wr_addr - INPUT_BASE) >> 2);
        wr_wt_idx = IDX_W'((wr_addr - WEIGHT_BASE) >> 2);
        rd_in_idx = IDX_W'((rd_addr - INPUT_BASE) >> 2);
        rd_wt_idx = IDX_W'((rd_addr - WEIGHT_BASE) >> 2);
    end

    // Operand and start writes are rejected while the engine runs; irq_en is not.
    assign wr_start    = wr_en && (wr_addr == CTRL_OFFSET) && s_axi_wstrb[0]
                         && s_axi_wdata[CTRL_START_BIT];
    assign wr_data_reg = wr_en && ((wr_addr == BIAS_OFFSET) || wr_in_sel || wr_wt_sel);
    assign wr_err      = busy && (wr_start || wr_data_reg);
    assign core_start  = wr_start && !busy;
    assign clr_done    = wr_en && (wr_addr == STATUS_OFFSET) && s_axi_wdata[STATUS_DONE_BIT];
    assign clr_ovf     = wr_en && (wr_addr == STATUS_OFFSET) && s_axi_wdata[STATUS_OVF_BIT];
    assign irq         = done && irq_en;
    assign s_axi_rresp = RESP_OKAY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_en   <= 1'b0;
            bias_reg <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                input_reg[i]  <= '0;
                weight_reg[i] <= '0;
            end
        end else if (wr_en) begin
            if ((wr_addr == CTRL_OFFSET) && s_axi_wstrb[0]) begin
                irq_en <= s_axi_wdata[CTRL_IRQ_EN_BIT];
            end
            if (!busy) begin
                if (wr_addr == BIAS_OFFSET) begin
                    bias_reg <= apply_wstrb(bias_reg, s_axi_wdata, s_axi_wstrb);
                end
                if (wr_in_sel) begin
                    input_reg[wr_in_idx] <= apply_wstrb(input_reg[wr_in_idx], s_axi_wdata, s_axi_wstrb);
                end
                if (wr_wt_sel) begin
                    weight_reg[wr_wt_idx] <= apply_wstrb(weight_reg[wr_wt_idx], s_axi_wdata, s_axi_wstrb);
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_addr == CTRL_OFFSET) begin
            rd_val[CTRL_IRQ_EN_BIT] = irq_en;
        end else if (rd_addr == STATUS_OFFSET) begin
            rd_val[STATUS_BUSY_BIT] = busy;
            rd_val[STATUS_DONE_BIT] = done;
            rd_val[STATUS_OVF_BIT]  = ovf;
        end else if (rd_addr == BIAS_OFFSET) begin
            rd_val = bias_reg;
        end else if (rd_addr == RESULT_OFFSET) begin
            rd_val = result;
        end else if (rd_in_sel) begin
            rd_val = input_reg[rd_in_idx];
        end else if (rd_wt_sel) begin
            rd_val = weight_reg[rd_wt_idx];
        end
    end

    // Ready signals are one-cycle pulses; a single write and a single read may be in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            if (wr_en) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_en) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    neuron_mac_core #(
        .W         (W),
        .N         (N_INPUTS),
        .FRAC_BITS (FRAC_BITS),
        .IDX_W     (IDX_W)
    ) u_core (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .start     (core_start),
        .clr_done  (clr_done),
        .clr_ovf   (clr_ovf),
        .bias      (bias_reg),
        .op_idx    (core_idx),
        .op_input  (input_reg[core_idx]),
        .op_weight (weight_reg[core_idx]),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .result    (result)
    );

endmodule
